// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-style instruction and data ports onto one AXI4 master,
// one outstanding single-beat transaction per port, with a one-entry fetch hit buffer.
module sram_axi_bridge #(
  parameter logic [3:0] RD_ID_I = 4'd0,
  parameter logic [3:0] RD_ID_D = 4'd1,
  parameter logic [3:0] WR_ID   = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        stallreq_from_i,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_from_d,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {I_IDLE, I_AR, I_R, I_DONE} i_state_e;
  typedef enum logic [2:0] {D_IDLE, D_RAR, D_RR, D_WADDR, D_WRESP, D_DONE} d_state_e;

  i_state_e    i_state_q, i_state_d;
  d_state_e    d_state_q, d_state_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic        i_lock_q, i_lock_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:2] d_addr_q, d_addr_d;
  logic [3:0]  d_wen_q, d_wen_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        hit, i_ar_go, d_ar_go, d_blocks_i;
  logic        unused_ok;

  function automatic logic [1:0] low_strb(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [2:0] strb_size(input logic [3:0] s);
    logic [2:0] n;
    n = {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
    case (n)
      3'd1:    return 3'd0;
      3'd2:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  assign hit = inst_sram_en & buf_valid_q & (inst_sram_addr == buf_addr_q);

  // Once an inst AR is on the bus it keeps it (lock) so araddr cannot change under arvalid.
  assign d_blocks_i = (d_state_q == D_RAR) | (d_state_q == D_WADDR) | (d_state_q == D_WRESP);
  assign i_ar_go    = (i_state_q == I_AR) & (i_lock_q | ~d_blocks_i);
  assign d_ar_go    = (d_state_q == D_RAR) & ~i_lock_q;

  assign arvalid = i_ar_go | d_ar_go;
  assign araddr  = d_ar_go ? {d_addr_q, 2'b00} : (i_ar_go ? i_addr_q : 32'd0);
  assign arid    = d_ar_go ? RD_ID_D : RD_ID_I;
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign rready  = (i_state_q == I_R) | (d_state_q == D_RR);

  assign awid    = WR_ID;
  assign awaddr  = {d_addr_q, low_strb(d_wen_q)};
  assign awlen   = 8'd0;
  assign awsize  = strb_size(d_wen_q);
  assign awburst = 2'b01;
  assign awvalid = (d_state_q == D_WADDR) & ~aw_done_q;
  assign wdata   = d_wdata_q;
  assign wstrb   = d_wen_q;
  assign wlast   = 1'b1;
  assign wvalid  = (d_state_q == D_WADDR) & ~w_done_q;
  assign bready  = (d_state_q == D_WRESP);

  assign stallreq_from_i = ((i_state_q == I_IDLE) & inst_sram_en & ~hit) |
                           (i_state_q == I_AR) | (i_state_q == I_R);
  assign inst_sram_rdata = (((i_state_q == I_IDLE) & hit) | (i_state_q == I_DONE)) ? buf_data_q : 32'd0;
  assign stallreq_from_d = ((d_state_q == D_IDLE) & data_sram_en) |
                           ((d_state_q != D_IDLE) & (d_state_q != D_DONE));
  assign data_sram_rdata = d_rdata_q;

  assign unused_ok = ^{rresp, rlast, bid, bresp, data_sram_addr[1:0]};

  always_comb begin
    i_state_d   = i_state_q;
    i_addr_d    = i_addr_q;
    i_lock_d    = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    d_state_d   = d_state_q;
    d_addr_d    = d_addr_q;
    d_wen_d     = d_wen_q;
    d_wdata_d   = d_wdata_q;
    d_rdata_d   = d_rdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    case (i_state_q)
      I_IDLE: if (inst_sram_en & ~hit) begin
        i_state_d = I_AR;
        i_addr_d  = inst_sram_addr;
      end
      I_AR: if (i_ar_go) begin
        if (arready) i_state_d = I_R;
        else         i_lock_d  = 1'b1;
      end
      I_R: if (rvalid & (rid == RD_ID_I)) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = i_addr_q;
        buf_data_d  = rdata;
        i_state_d   = I_DONE;
      end
      default: i_state_d = I_IDLE;
    endcase

    case (d_state_q)
      D_IDLE: if (data_sram_en) begin
        d_addr_d  = data_sram_addr[31:2];
        d_wen_d   = data_sram_wen;
        d_wdata_d = data_sram_wdata;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (data_sram_wen == 4'd0) begin
          d_state_d = D_RAR;
        end else begin
          d_state_d = D_WADDR;
          // A store to the buffered word makes the buffered instruction stale.
          if (data_sram_addr[31:2] == buf_addr_d[31:2]) buf_valid_d = 1'b0;
        end
      end
      D_RAR: if (d_ar_go & arready) d_state_d = D_RR;
      D_RR: if (rvalid & (rid == RD_ID_D)) begin
        d_rdata_d = rdata;
        d_state_d = D_DONE;
      end
      D_WADDR: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if ((aw_done_q | awready) & (w_done_q | wready)) d_state_d = D_WRESP;
      end
      D_WRESP: if (bvalid) d_state_d = D_DONE;
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_state_q   <= I_IDLE;
      d_state_q   <= D_IDLE;
      i_lock_q    <= 1'b0;
      buf_valid_q <= 1'b0;
      d_rdata_q   <= 32'd0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      i_state_q   <= i_state_d;
      d_state_q   <= d_state_d;
      i_lock_q    <= i_lock_d;
      buf_valid_q <= buf_valid_d;
      d_rdata_q   <= d_rdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  always_ff @(posedge clk) begin
    i_addr_q   <= i_addr_d;
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
    d_addr_q   <= d_addr_d;
    d_wen_q    <= d_wen_d;
    d_wdata_q  <= d_wdata_d;
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave cycle by cycle
// and checks core-side and bus-side outputs against hand-derived values.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        stallreq_from_i;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_from_d;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;
  int ar_hs = 0;
  int base, cnt;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .stallreq_from_i(stallreq_from_i),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_from_d(stallreq_from_d),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (resetn && arvalid && arready) ar_hs <= ar_hs + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; inst_sram_en = 1'b0; inst_sram_addr = 32'd0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

    // Reset state and constant fields
    tick(); tick();
    samp();
    check("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("rst_stalls", {30'd0, stallreq_from_i, stallreq_from_d}, 32'd0);
    check("rst_irdata", inst_sram_rdata, 32'd0);
    check("rst_drdata", data_sram_rdata, 32'd0);
    check("const_fields", {8'd0, arlen, awlen, arburst, awburst, arsize, wlast},
          {8'd0, 8'd0, 8'd0, 2'b01, 2'b01, 3'd2, 1'b1});
    tick();
    resetn = 1'b1;
    tick();

    // Fetch miss with slow AR and R, then a zero-stall hit
    base = ar_hs; cnt = 0;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    for (int k = 0; k < 6; k++) begin
      arready = (k == 2);
      rvalid  = (k == 5);
      rid     = 4'd0;
      rdata   = (k == 5) ? 32'h3C08_BFAF : 32'd0;
      samp();
      if (stallreq_from_i) cnt++;
      if (k == 1) begin
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_araddr", araddr, 32'hBFC0_0000);
        check("t1_arid", {28'd0, arid}, 32'd0);
      end
      tick();
    end
    check("t1_stall_cycles", cnt, 32'd6);
    arready = 1'b0; rvalid = 1'b0;
    samp();
    check("t1_done_stall", {31'd0, stallreq_from_i}, 32'd0);
    check("t1_done_rdata", inst_sram_rdata, 32'h3C08_BFAF);
    tick();
    samp();
    check("t1_hit_stall", {31'd0, stallreq_from_i}, 32'd0);
    check("t1_hit_rdata", inst_sram_rdata, 32'h3C08_BFAF);
    check("t1_hit_noar", {31'd0, arvalid}, 32'd0);
    check("t1_ar_count", ar_hs - base, 32'd1);
    tick();
    inst_sram_en = 1'b0;
    tick();

    // Simultaneous inst miss and data load; inst R returns first
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0010;
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_0004;
    samp();
    check("t2_stalls", {30'd0, stallreq_from_i, stallreq_from_d}, 32'd3);
    tick();
    arready = 1'b1;
    samp();
    check("t2_first_arid", {28'd0, arid}, 32'd1);
    check("t2_first_araddr", araddr, 32'h8000_0004);
    tick();
    samp();
    check("t2_second_arvalid", {31'd0, arvalid}, 32'd1);
    check("t2_second_arid", {28'd0, arid}, 32'd0);
    check("t2_second_araddr", araddr, 32'hBFC0_0010);
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_1111;
    samp();
    check("t2_rready", {31'd0, rready}, 32'd1);
    tick();
    rid = 4'd1; rdata = 32'h2222_2222;
    samp();
    check("t2_i_rdata", inst_sram_rdata, 32'h1111_1111);
    check("t2_d_stall", {31'd0, stallreq_from_d}, 32'd1);
    tick();
    rvalid = 1'b0;
    samp();
    check("t2_d_rdata", data_sram_rdata, 32'h2222_2222);
    check("t2_d_done_stall", {31'd0, stallreq_from_d}, 32'd0);
    check("t2_i_hit_rdata", inst_sram_rdata, 32'h1111_1111);
    tick();
    inst_sram_en = 1'b0; data_sram_en = 1'b0;
    tick();

    // Byte store, AW accepted before W
    data_sram_en = 1'b1; data_sram_wen = 4'b0100;
    data_sram_addr = 32'h8000_1002; data_sram_wdata = 32'hAABB_CCDD;
    samp();
    check("t3_idle_stall", {31'd0, stallreq_from_d}, 32'd1);
    tick();
    awready = 1'b1;
    samp();
    check("t3_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    check("t3_awaddr", awaddr, 32'h8000_1002);
    check("t3_awsize", {29'd0, awsize}, 32'd0);
    check("t3_wstrb", {28'd0, wstrb}, 32'h4);
    check("t3_wdata", wdata, 32'hAABB_CCDD);
    tick();
    awready = 1'b0; wready = 1'b1;
    samp();
    check("t3_w_only", {30'd0, awvalid, wvalid}, 32'd1);
    tick();
    wready = 1'b0;
    samp();
    check("t3_bready", {31'd0, bready}, 32'd1);
    tick();
    bvalid = 1'b1;
    samp();
    check("t3_bvalid_stall", {31'd0, stallreq_from_d}, 32'd1);
    tick();
    bvalid = 1'b0; data_sram_en = 1'b0;
    samp();
    check("t3_stall_clear", {31'd0, stallreq_from_d}, 32'd0);
    tick();

    // Halfword store to the buffered PC word, then refetch misses
    data_sram_en = 1'b1; data_sram_wen = 4'b1100;
    data_sram_addr = 32'hBFC0_0010; data_sram_wdata = 32'h1234_5678;
    tick();
    awready = 1'b1; wready = 1'b1;
    samp();
    check("t4_awaddr", awaddr, 32'hBFC0_0012);
    check("t4_awsize", {29'd0, awsize}, 32'd1);
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    tick();
    bvalid = 1'b0; data_sram_en = 1'b0;
    tick();
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0010;
    samp();
    check("t4_miss_stall", {31'd0, stallreq_from_i}, 32'd1);
    tick();
    arready = 1'b1;
    samp();
    check("t4_refetch_ar", {31'd0, arvalid}, 32'd1);
    check("t4_refetch_addr", araddr, 32'hBFC0_0010);
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_5555;
    tick();
    rvalid = 1'b0;
    samp();
    check("t4_refetch_rdata", inst_sram_rdata, 32'h5555_5555);
    tick();
    inst_sram_en = 1'b0;
    tick();

    // Inst miss while a write is pending: AR held off until the write completes
    data_sram_en = 1'b1; data_sram_wen = 4'b1111;
    data_sram_addr = 32'h8000_2000; data_sram_wdata = 32'hCAFE_F00D;
    tick();
    awready = 1'b1; wready = 1'b1;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0020;
    samp();
    check("t5_awsize", {29'd0, awsize}, 32'd2);
    check("t5_awaddr", awaddr, 32'h8000_2000);
    check("t5_i_stall", {31'd0, stallreq_from_i}, 32'd1);
    tick();
    awready = 1'b0; wready = 1'b0; data_sram_en = 1'b0; cnt = 0;
    for (int k = 0; k < 3; k++) begin
      bvalid = (k == 2);
      samp();
      if (arvalid) cnt++;
      tick();
    end
    check("t5_no_ar_during_write", cnt, 32'd0);
    bvalid = 1'b0;
    samp();
    check("t5_ar_after_b", {31'd0, arvalid}, 32'd1);
    check("t5_ar_addr", araddr, 32'hBFC0_0020);
    check("t5_d_stall", {31'd0, stallreq_from_d}, 32'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h6666_6666;
    tick();
    rvalid = 1'b0;
    samp();
    check("t5_i_rdata", inst_sram_rdata, 32'h6666_6666);
    tick();
    inst_sram_en = 1'b0;
    tick();

    // Reset while waiting for read data; the late beat must be ignored
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_3000;
    tick();
    arready = 1'b1;
    samp();
    check("t6_arid", {28'd0, arid}, 32'd1);
    check("t6_araddr", araddr, 32'h8000_3000);
    tick();
    arready = 1'b0;
    samp();
    check("t6_rr_state", {30'd0, rready, stallreq_from_d}, 32'd3);
    resetn = 1'b0; data_sram_en = 1'b0;
    tick();
    samp();
    check("t6_rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("t6_rst_stalls", {30'd0, stallreq_from_i, stallreq_from_d}, 32'd0);
    check("t6_rst_drdata", data_sram_rdata, 32'd0);
    resetn = 1'b1; rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    samp();
    check("t6_late_drdata", data_sram_rdata, 32'd0);
    check("t6_late_irdata", inst_sram_rdata, 32'd0);
    check("t6_late_flags", {29'd0, rready, stallreq_from_i, stallreq_from_d}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core. Converts the core's SRAM-like instruction and data ports into a single AXI4 master.
- Generates `stallreq_from_i` and `stallreq_from_d` back to the core.
- Supports one outstanding transaction per port: single-beat reads and single-beat writes.
- Holds a one-entry instruction hit buffer so the core can re-present a stalled PC without refetching it.

Parameters:
- RD_ID_I, 4'd0, ARID used for instruction reads.
- RD_ID_D, 4'd1, ARID used for data reads.
- WR_ID, 4'd1, AWID used for data writes.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `inst_sram_en` in 1: fetch request.
- `inst_sram_addr` in 32: fetch address, word aligned.
- `inst_sram_rdata` out 32: fetched instruction.
- `stallreq_from_i` out 1: fetch not yet complete.
- `data_sram_en` in 1: data access request.
- `data_sram_wen` in 4: byte strobes; 0 means read.
- `data_sram_addr` in 32: data address.
- `data_sram_wdata` in 32: store data.
- `data_sram_rdata` out 32: load data.
- `stallreq_from_d` out 1: data access not yet complete.
- AR channel: `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1.
- R channel: `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- AW channel: `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1.
- W channel: `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- B channel: `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1.

Behaviour:
- Reset (`resetn`=0 at a clock edge):
  - Both FSMs go to IDLE; hit buffer invalid.
  - All `*valid` outputs low, `rready`/`bready` low, both stalls low, both rdata outputs 0.
  - Reset mid-transaction abandons it; the interconnect is reset together with the bridge.
- Constant outputs: `arlen`=`awlen`=0, `arburst`=`awburst`=2'b01, `arsize`=3'd2, `wlast`=1.
- Inst FSM states: IDLE, AR, R, DONE.
  - Hit: `inst_sram_en` & buffer valid & `inst_sram_addr`==buffer address. `stallreq_from_i`=0 and `inst_sram_rdata`=buffer data in the same cycle; no AXI traffic.
  - IDLE, en & miss: go to AR, latch the address, `stallreq_from_i`=1 combinationally in this cycle.
  - AR: `arvalid`=1 with `araddr`=latched address and `arid`=RD_ID_I; hold until `arready`, then go to R.
  - R: on `rvalid` & `rid`==RD_ID_I, write `rdata` and the address into the buffer, set valid, go to DONE.
  - DONE: stall=0 and rdata=buffer data; return to IDLE next cycle.
  - `stallreq_from_i`=1 in IDLE-with-miss, AR and R.
- Data FSM states: IDLE, RAR, RR, WADDR, WRESP, DONE.
  - Read (`wen`==0): RAR drives `araddr`={addr[31:2],2'b00}, `arid`=RD_ID_D, then RR waits for `rid`==RD_ID_D.
  - Read data is registered into `data_sram_rdata`; DONE lasts exactly one cycle.
  - Write: WADDR drives AW and W simultaneously. Each valid drops independently on its own handshake. Go to WRESP when both have completed (same or different cycles).
  - WRESP: `bready`=1; on `bvalid` go to DONE.
  - `awsize` by strobe count: 1 bit -> 0, 2 bits -> 1, 4 bits -> 2. Any other strobe pattern is treated as size 2.
  - `awaddr`={addr[31:2], index of lowest set strobe bit}. `wdata` and `wstrb` pass through unchanged.
  - `stallreq_from_d`=1 in IDLE-with-en and in every state except DONE.
  - Any write whose word address equals the buffer address clears buffer valid, in the cycle it enters WADDR.
- AR arbitration:
  - A single AR register is shared by both ports.
  - If both ports want AR in the same cycle, data wins; inst waits in AR with `arvalid` off.
  - An inst AR is not issued while the data FSM is in WADDR or WRESP.
  - `araddr`/`arid` stay stable while `arvalid` is high and `arready` is low.
- R routing:
  - `rready`=1 whenever either FSM is in its R state; the beat is routed by `rid`.
  - An unexpected `rid` is accepted and dropped.
  - `rresp`/`bresp` errors are ignored; the data is delivered as-is.

Test Plan:
- Fetch 0xBFC00000 with `arready` delayed 2 cycles and `rdata`=0x3C08BFAF after 3 more: AR seen once, `stallreq_from_i`=1 for 6 cycles, then low with rdata 0x3C08BFAF. Re-presenting the same PC gives a zero-stall hit.
- Inst miss and data load in the same cycle: data AR issued first (`arid`=1). Respond with inst R before data R; each port receives its own data.
- Store `wen`=4'b0100 at 0x80001002 with `awready` before `wready`: `awaddr`=0x80001002, `awsize`=0. Stall clears the cycle after `bvalid`.
- Store to the buffered PC's word: the next fetch of that PC misses and issues a new AR.
- Inst miss during a pending write: no `arvalid` until `bvalid`; the inst AR appears the next cycle.
- `resetn` low while in RR: all valids, `rready` and stalls low next edge. The dropped late R beat changes no output.
